// File: rtl/pipe_ctrl.sv
// Pipeline control: issue gating, commit-exception kill mask, flush sequencing and stall counter.
// Optional stall counter is enabled by defining PIPE_CTRL_PERF_EN; otherwise stall_cnt is 0.
module pipe_ctrl #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned NUM_FULL  = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    valid_fetch,
    input  logic [WIDTH-1:0]                        valid_dec,
    input  logic [NUM_FULL-1:0]                     full_vec,
    input  logic [WIDTH-1:0]                        commit_valid,
    input  logic [WIDTH-1:0]                        commit_regwr,
    input  logic [WIDTH-1:0]                        commit_exp,
    output logic [WIDTH-1:0]                        valid_issue,
    output logic [WIDTH-1:0]                        commit_kill,
    output logic                                    freeze_front,
    output logic                                    freeze_back,
    output logic                                    flush,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] flush_lane,
    output logic [15:0]                             stall_cnt
);

    localparam int unsigned LaneW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] FlushInit = 4'(FLUSH_CYC - 1);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StFlush   = 2'd1;
    localparam logic [1:0] StRecover = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [LaneW-1:0] lane_q, lane_d;
    logic             flush_q, flush_d;

    logic [WIDTH-1:0] exc;
    logic             exc_any;
    logic [LaneW-1:0] exc_lane;
    logic             seen;

    // Kill mask: a lane is killed when any older lane excepts this cycle.
    always_comb begin
        exc         = commit_valid & commit_regwr & commit_exp;
        exc_any     = |exc;
        seen        = 1'b0;
        commit_kill = '0;
        exc_lane    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            commit_kill[i] = seen;
            seen           = seen | exc[i];
        end
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (exc[i]) exc_lane = LaneW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        case (state_q)
            StRun, StRecover: begin
                if (exc_any) begin
                    state_d = StFlush;
                    cnt_d   = FlushInit;
                    lane_d  = exc_lane;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StRun;
        endcase
        flush_d = (state_d == StFlush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            lane_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        freeze_front = (|full_vec) | (state_q != StRun);
        freeze_back  = (state_q == StFlush);
        valid_issue  = valid_dec & {WIDTH{valid_fetch & ~freeze_front}};
        flush        = flush_q;
        flush_lane   = lane_q;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (freeze_front && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
